// File: rtl/mux_key_reverse_search_pkg.sv
// Shared definitions for the MuxKey reverse-search block: FSM states and width helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mux_key_reverse_search_pkg;

    // Scan FSM: wait for request, walk the LUT, hold the response.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Width of one packed {key,data} pair.
    function automatic int pair_len(input int key_len, input int data_len);
        return key_len + data_len;
    endfunction

    // Index width; a single-entry LUT still carries a 1-bit index.
    function automatic int idx_w(input int nr_key);
        return (nr_key > 1) ? $clog2(nr_key) : 1;
    endfunction

endpackage

// File: rtl/mux_key_reverse_search_if.sv
// Request/response bus of the reverse search: data in, {key,hit,index} out.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response channel.
interface mux_key_reverse_search_if #(
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 4,
    parameter int IDX_W    = 2
);
    logic                req_valid;
    logic                req_ready;
    logic [DATA_LEN-1:0] req_data;
    logic                resp_valid;
    logic                resp_ready;
    logic [KEY_LEN-1:0]  resp_key;
    logic                resp_hit;
    logic [IDX_W-1:0]    resp_index;

    // Requester side: issues searches and consumes responses.
    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_key, resp_hit, resp_index
    );

    // Search engine side.
    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_key, resp_hit, resp_index
    );
endinterface

// File: rtl/mux_key_reverse_search_pair_sel.sv
// Picks pair[idx] out of the packed LUT and splits it into key (upper) and data (lower).
// Latency: combinational.
// Backpressure: none.
module mux_key_reverse_search_pair_sel
    import mux_key_reverse_search_pkg::*;
#(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 4
) (
    input  logic [NR_KEY*pair_len(KEY_LEN, DATA_LEN)-1:0] lut,
    input  logic [idx_w(NR_KEY)-1:0]                       idx,
    output logic [KEY_LEN-1:0]                             key,
    output logic [DATA_LEN-1:0]                            data
);
    localparam int PAIR_LEN = pair_len(KEY_LEN, DATA_LEN);

    logic [PAIR_LEN-1:0] pairs [NR_KEY];
    logic [PAIR_LEN-1:0] pair;

    for (genvar n = 0; n < NR_KEY; n++) begin : g_pair
        assign pairs[n] = lut[PAIR_LEN*(n+1)-1 : PAIR_LEN*n];
    end

    assign pair = pairs[idx];
    assign key  = pair[PAIR_LEN-1 -: KEY_LEN];
    assign data = pair[DATA_LEN-1:0];
endmodule

// File: rtl/mux_key_reverse_search.sv
// Reverse LUT lookup: finds the lowest-index pair whose data equals the request, one entry per clock.
// Latency: hit at index n -> response n+1 clocks after accept; miss -> NR_KEY clocks.
// Backpressure: single outstanding search; req_ready only in IDLE, response held until resp_ready.
module mux_key_reverse_search
    import mux_key_reverse_search_pkg::*;
#(
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 2,
    parameter int DATA_LEN    = 4,
    parameter bit HAS_DEFAULT = 1'b0
) (
    input  logic                                           clk,
    input  logic                                           rst,
    mux_key_reverse_search_if.slave                        bus,
    input  logic [NR_KEY*pair_len(KEY_LEN, DATA_LEN)-1:0]  lut,
    input  logic [KEY_LEN-1:0]                             default_key
);
    localparam int IDX_W = idx_w(NR_KEY);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_KEY - 1);

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [DATA_LEN-1:0] req_lat;
    logic [KEY_LEN-1:0]  sel_key;
    logic [DATA_LEN-1:0] sel_data;
    logic                match;
    logic                last;
    logic [KEY_LEN-1:0]  resp_key;
    logic                resp_hit;
    logic [IDX_W-1:0]    resp_index;

    mux_key_reverse_search_pair_sel #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN)
    ) u_pair_sel (
        .lut  (lut),
        .idx  (idx),
        .key  (sel_key),
        .data (sel_data)
    );

    // LUT is read live during the scan; the caller keeps it stable until the response.
    assign match = (sel_data == req_lat);
    assign last  = (idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: accept in IDLE, stop scanning on first hit or last entry, leave RESP on handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.req_valid)    state_nxt = S_SCAN;
            S_SCAN:  if (match || last)    state_nxt = S_RESP;
            S_RESP:  if (bus.resp_ready)   state_nxt = S_IDLE;
            default:                       state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch the search value, advance the index, capture the result when the scan ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            req_lat    <= '0;
            resp_key   <= '0;
            resp_hit   <= 1'b0;
            resp_index <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        req_lat <= bus.req_data;
                        idx     <= '0;
                    end
                end
                S_SCAN: begin
                    if (match) begin
                        resp_key   <= sel_key;
                        resp_hit   <= 1'b1;
                        resp_index <= idx;
                    end else if (last) begin
                        resp_key   <= HAS_DEFAULT ? default_key : '0;
                        resp_hit   <= 1'b0;
                        resp_index <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // All outputs come from state or registers; nothing combinational from the inputs.
    assign bus.req_ready  = (state == S_IDLE);
    assign bus.resp_valid = (state == S_RESP);
    assign bus.resp_key   = resp_key;
    assign bus.resp_hit   = resp_hit;
    assign bus.resp_index = resp_index;
endmodule

// File: tb/tb_mux_key_reverse_search.sv
// Directed bench for the reverse search, run against a default-key and a zero-key instance in lockstep.
// Latency: expected response latency is carried in the scoreboard entry.
// Backpressure: exercises held responses, dropped requests while busy, and reset mid-scan.
module tb_mux_key_reverse_search;
    import mux_key_reverse_search_pkg::*;

    localparam int NR_KEY   = 4;
    localparam int KEY_LEN  = 2;
    localparam int DATA_LEN = 4;
    localparam int IDX_W    = idx_w(NR_KEY);
    localparam int LUT_W    = NR_KEY * pair_len(KEY_LEN, DATA_LEN);

    typedef struct {
        logic [KEY_LEN-1:0] key_d;
        logic [KEY_LEN-1:0] key_z;
        logic               hit;
        logic [IDX_W-1:0]   index;
        int                 lat;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                req_valid = 1'b0;
    logic [DATA_LEN-1:0] req_data = '0;
    logic                resp_ready = 1'b0;
    logic [LUT_W-1:0]    lut;
    logic [KEY_LEN-1:0]  default_key;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mux_key_reverse_search_if #(.KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .IDX_W(IDX_W)) bus_d ();
    mux_key_reverse_search_if #(.KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .IDX_W(IDX_W)) bus_z ();

    assign bus_d.req_valid  = req_valid;
    assign bus_d.req_data   = req_data;
    assign bus_d.resp_ready = resp_ready;
    assign bus_z.req_valid  = req_valid;
    assign bus_z.req_data   = req_data;
    assign bus_z.resp_ready = resp_ready;

    mux_key_reverse_search #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .HAS_DEFAULT(1'b1))
        dut_d (.clk(clk), .rst(rst), .bus(bus_d), .lut(lut), .default_key(default_key));
    mux_key_reverse_search #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .HAS_DEFAULT(1'b0))
        dut_z (.clk(clk), .rst(rst), .bus(bus_z), .lut(lut), .default_key(default_key));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for IDLE, presents one request for a single accepting edge, records the expected result.
    task automatic issue(input logic [DATA_LEN-1:0] d, input logic [KEY_LEN-1:0] kd,
                         input logic [KEY_LEN-1:0] kz, input logic h,
                         input logic [IDX_W-1:0] ix, input int lat);
        exp_t e;
        for (int i = 0; i < 20 && !bus_d.req_ready; i++) @(negedge clk);
        check("req_ready_before_issue", {31'd0, bus_d.req_ready}, 32'd1);
        e.key_d = kd; e.key_z = kz; e.hit = h; e.index = ix; e.lat = lat;
        sb.push_back(e);
        req_valid = 1'b1;
        req_data  = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Counts edges from accept until resp_valid, then compares against the oldest scoreboard entry.
    task automatic collect(input string tag);
        exp_t e;
        int   cnt;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e   = sb.pop_front();
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end while (!bus_d.resp_valid && cnt < 20);
        check({tag, "_latency"},   cnt, e.lat);
        check({tag, "_valid_d"},   {31'd0, bus_d.resp_valid}, 32'd1);
        check({tag, "_valid_z"},   {31'd0, bus_z.resp_valid}, 32'd1);
        check({tag, "_hit_d"},     {31'd0, bus_d.resp_hit}, {31'd0, e.hit});
        check({tag, "_hit_z"},     {31'd0, bus_z.resp_hit}, {31'd0, e.hit});
        check({tag, "_key_d"},     {30'd0, bus_d.resp_key}, {30'd0, e.key_d});
        check({tag, "_key_z"},     {30'd0, bus_z.resp_key}, {30'd0, e.key_z});
        check({tag, "_index_d"},   {30'd0, bus_d.resp_index}, {30'd0, e.index});
        check({tag, "_index_z"},   {30'd0, bus_z.resp_index}, {30'd0, e.index});
        check({tag, "_busy"},      {31'd0, bus_d.req_ready}, 32'd0);
    endtask

    // Completes the response handshake; IDLE must be visible the following cycle.
    task automatic release_resp(input string tag);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_rel_ready"}, {31'd0, bus_d.req_ready}, 32'd1);
        check({tag, "_rel_valid"}, {31'd0, bus_d.resp_valid}, 32'd0);
    endtask

    initial begin
        // pairs idx0..3 = {0,3},{1,A},{2,A},{3,7}
        lut         = {2'd3, 4'h7, 2'd2, 4'hA, 2'd1, 4'hA, 2'd0, 4'h3};
        default_key = 2'd2;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready",  {31'd0, bus_d.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus_d.resp_valid}, 32'd0);
        check("rst_resp_key",   {30'd0, bus_d.resp_key}, 32'd0);
        check("rst_resp_hit",   {31'd0, bus_d.resp_hit}, 32'd0);
        check("rst_resp_index", {30'd0, bus_d.resp_index}, 32'd0);

        // Hit at index 0
        issue(4'h3, 2'd0, 2'd0, 1'b1, 2'd0, 1);
        collect("hit0");
        release_resp("hit0");

        // Duplicate data: lowest index wins
        issue(4'hA, 2'd1, 2'd1, 1'b1, 2'd1, 2);
        collect("dupA");
        release_resp("dupA");

        // Hit at last index
        issue(4'h7, 2'd3, 2'd3, 1'b1, 2'd3, 4);
        collect("hit3");
        release_resp("hit3");

        // Miss: default key vs zero key
        issue(4'h5, 2'd2, 2'd0, 1'b0, 2'd0, 4);
        collect("miss");
        release_resp("miss");

        // Held response with a request pulse that must be dropped
        issue(4'h3, 2'd0, 2'd0, 1'b1, 2'd0, 1);
        collect("hold");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                req_valid = 1'b1;
                req_data  = 4'h7;
            end
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            check("hold_valid", {31'd0, bus_d.resp_valid}, 32'd1);
            check("hold_ready", {31'd0, bus_d.req_ready}, 32'd0);
            check("hold_key",   {30'd0, bus_d.resp_key}, 32'd0);
            check("hold_hit",   {31'd0, bus_d.resp_hit}, 32'd1);
            check("hold_index", {30'd0, bus_d.resp_index}, 32'd0);
        end
        release_resp("hold");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dropped_valid", {31'd0, bus_d.resp_valid}, 32'd0);
            check("dropped_ready", {31'd0, bus_d.req_ready}, 32'd1);
        end

        // Reset mid-scan at idx 2
        issue(4'h7, 2'd3, 2'd3, 1'b1, 2'd3, 4);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_ready_d", {31'd0, bus_d.req_ready}, 32'd1);
        check("midrst_ready_z", {31'd0, bus_z.req_ready}, 32'd1);
        check("midrst_valid",   {31'd0, bus_d.resp_valid}, 32'd0);
        check("midrst_hit",     {31'd0, bus_d.resp_hit}, 32'd0);
        issue(4'h7, 2'd3, 2'd3, 1'b1, 2'd3, 4);
        collect("after_rst");
        release_resp("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
